aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
On-the-fly AES-128 key expansion unit. It sits directly upstream of the encryption control FSM and the round datapath, and supplies one 128-bit round key per round. It answers each single-cycle req_key pulse from the FSM by advancing to the next round key one clock later, so no 11-entry key RAM is needed. It tracks the round index and Rcon internally and flags out-of-sequence requests.

Parameters:
NUM_ROUNDS, 10, number of key advances per cipher key; only 10 is legal (AES-128), and elaboration fails otherwise.
ERR_STICKY, 1, 1: key_err holds until the next load_key; 0: key_err is a 1-cycle pulse.

Ports:
clk  input  1  single clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
load_key  input  1  1-cycle strobe that latches cipher_key as round key 0.
cipher_key  input  128  AES-128 cipher key; bits [127:96] hold word w0 (FIPS-197 byte order).
req_key  input  1  advance request from the encryption FSM; sampled every cycle.
round_key  output  128  current round key, registered.
round_idx  output  4  index of the round key on round_key (0..10).
key_valid  output  1  round_key holds a valid key for the loaded cipher key.
key_last  output  1  high while round_idx == NUM_ROUNDS.
key_err  output  1  req_key arrived in IDLE or EXHAUSTED.

Behaviour:
- State machine ks_state_e has three states: IDLE, READY, EXHAUSTED. All outputs are registered.
- Reset (the synchronous check has highest priority) sets: state=IDLE, round_key=0, round_idx=0, rcon=8'h01, key_valid=0, key_last=0, key_err=0.
- load_key in any state, next cycle:
  - round_key=cipher_key, round_idx=0, rcon=8'h01.
  - key_valid=1, key_last=0, key_err=0, state=READY.
  - load_key beats req_key in the same cycle; that req_key is dropped silently with no error.
- req_key in READY, next cycle:
  - round_key=expand(round_key, rcon); round_idx+=1; rcon=xtime(rcon).
  - xtime: shift left by 1; if bit 7 was set, XOR with 8'h1B. So 8'h80 becomes 8'h1B, and 8'h1B becomes 8'h36.
  - When the new round_idx reaches NUM_ROUNDS: state=EXHAUSTED and key_last=1.
  - Latency is exactly 1 cycle from req_key to the new key. req_key held for N cycles advances N rounds.
- expand (combinational, single cycle):
  - Split the current key into words w0..w3, with w0 = [127:96].
  - t = SubWord(RotWord(w3)) XOR {rcon, 24'h0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord maps {a,b,c,d} to {b,c,d,a}. SubWord applies the S-box to each byte, using 4 instances.
- req_key in IDLE or EXHAUSTED:
  - round_key, round_idx and rcon do not change.
  - key_err=1 from the next cycle. It is sticky or a pulse according to ERR_STICKY.
  - key_valid stays at its current value.
- EXHAUSTED keeps round key 10 on round_key until load_key or reset.
- Reset while keys are being advanced returns to IDLE with key_valid=0. A later req_key before load_key raises key_err.
- Between advances, round_key is stable and never glitches. Consumers sample it at any cycle after the advance edge.

Decomposition:
- Shared package aes_pkg holds:
  - ks_state_e {IDLE, READY, EXHAUSTED}
  - AES128_ROUNDS = 10
  - RCON_INIT = 8'h01
  - RCON_REDUCE = 8'h1B
  - function xtime(byte)
  - function rot_word(word)
- One sub-module, aes_sbox: purely combinational, 8-bit in and 8-bit out, forward S-box as a 256-entry case. It is instantiated 4 times here and reused by the round datapath SubBytes.

Test Plan:
1. Reset; then req_key for 1 cycle with no load -> round_key=0, round_idx=0, key_valid=0, key_err=1 (sticky).
2. load_key with cipher_key=128'h2b7e151628aed2a6abf7158809cf4f3c, then a single req_key -> next cycle round_key=128'ha0fafe1788542cb123a339392a6c7605, round_idx=1, key_err=0.
3. Same key, 10 req_key pulses spaced 3 cycles apart -> round 10 round_key=128'hd014f9a8c9ee2589e13f0cc8b6630ca6, key_last=1, state=EXHAUSTED; internal rcon sequence 01,02,04,08,10,20,40,80,1b,36.
4. An 11th req_key in EXHAUSTED -> round_key unchanged, round_idx=10, key_err=1. With ERR_STICKY=0, key_err falls after 1 cycle.
5. load_key and req_key in the same cycle after round 5 -> round_key=cipher_key, round_idx=0, key_err=0.
6. reset asserted mid-sequence at round_idx=4 -> next cycle all outputs at reset values; the following load_key plus req_key reproduces the scenario-2 key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the key schedule and round datapath.
package aes_pkg;

  localparam int          AES128_ROUNDS = 10;
  localparam logic [7:0]  RCON_INIT     = 8'h01;
  localparam logic [7:0]  RCON_REDUCE   = 8'h1B;

  typedef logic [127:0] aes_key_t;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    EXHAUSTED
  } ks_state_e;

  // GF(2^8) multiply by x, reduced by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_REDUCE : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-schedule bus between the encryption FSM (master) and the key expander (slave).
interface aes_key_schedule_if;
  import aes_pkg::*;

  logic       load_key;
  aes_key_t   cipher_key;
  logic       req_key;
  aes_key_t   round_key;
  logic [3:0] round_idx;
  logic       key_valid;
  logic       key_last;
  logic       key_err;

  modport master (
    output load_key, cipher_key, req_key,
    input  round_key, round_idx, key_valid, key_last, key_err
  );

  modport slave (
    input  load_key, cipher_key, req_key,
    output round_key, round_idx, key_valid, key_last, key_err
  );
endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational; shared with the round datapath SubBytes.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  always_comb begin
    o_byte = 8'h00;
    case (i_byte)
      8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
      8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
      8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
      8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
      8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
      8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
      8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
      8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
      8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
      8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
      8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
      8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
      8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
      8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
      8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
      8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
      8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
      8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
      8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
      8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
      8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
      8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
      8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
      8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
      8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
      8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
      8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
      8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
      8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
      8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
      8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
      default: o_byte = 8'h00;
    endcase
  end
endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 key expansion: one registered round key per req_key pulse,
// with round index and Rcon tracked internally.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_schedule_if.slave  ks
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
    $error("aes_key_schedule: NUM_ROUNDS must be %0d", AES128_ROUNDS);
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e  r_state, w_state_nxt;
  aes_key_t   r_round_key, w_round_key_nxt, w_expanded;
  logic [3:0] r_round_idx, w_round_idx_nxt, w_idx_inc;
  logic [7:0] r_rcon, w_rcon_nxt;
  logic       r_key_valid, w_key_valid_nxt;
  logic       r_key_last, w_key_last_nxt;
  logic       r_key_err, w_key_err_nxt;
  logic       w_adv, w_bad, w_hit_last;

  // load_key wins over a coincident req_key, which is then dropped silently.
  assign w_adv      = ks.req_key && !ks.load_key && (r_state == READY);
  assign w_bad      = ks.req_key && !ks.load_key && (r_state != READY);
  assign w_idx_inc  = r_round_idx + 4'd1;
  assign w_hit_last = (w_idx_inc == LAST_IDX);

  // ---- single-cycle key expansion ----
  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
  assign w_rot = rot_word(w_w3);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.i_byte(w_rot[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
  end

  assign w_t  = w_sub ^ {r_rcon, 24'h0};
  assign w_n0 = w_w0 ^ w_t;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;
  assign w_expanded = {w_n0, w_n1, w_n2, w_n3};

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    if (ks.load_key)             w_state_nxt = READY;
    else if (w_adv && w_hit_last) w_state_nxt = EXHAUSTED;
  end

  // ---- FSM: outputs (next values of the registered outputs) ----
  always_comb begin
    w_round_key_nxt = r_round_key;
    w_round_idx_nxt = r_round_idx;
    w_rcon_nxt      = r_rcon;
    w_key_valid_nxt = r_key_valid;
    w_key_last_nxt  = r_key_last;
    w_key_err_nxt   = ERR_STICKY ? r_key_err : 1'b0;
    if (ks.load_key) begin
      w_round_key_nxt = ks.cipher_key;
      w_round_idx_nxt = 4'd0;
      w_rcon_nxt      = RCON_INIT;
      w_key_valid_nxt = 1'b1;
      w_key_last_nxt  = 1'b0;
      w_key_err_nxt   = 1'b0;
    end else if (w_adv) begin
      w_round_key_nxt = w_expanded;
      w_round_idx_nxt = w_idx_inc;
      w_rcon_nxt      = xtime(r_rcon);
      w_key_last_nxt  = w_hit_last;
    end else if (w_bad) begin
      w_key_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_round_key <= '0;
      r_round_idx <= 4'd0;
      r_rcon      <= RCON_INIT;
      r_key_valid <= 1'b0;
      r_key_last  <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      r_round_key <= w_round_key_nxt;
      r_round_idx <= w_round_idx_nxt;
      r_rcon      <= w_rcon_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_last  <= w_key_last_nxt;
      r_key_err   <= w_key_err_nxt;
    end
  end

  assign ks.round_key = r_round_key;
  assign ks.round_idx = r_round_idx;
  assign ks.key_valid = r_key_valid;
  assign ks.key_last  = r_key_last;
  assign ks.key_err   = r_key_err;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: FIPS-197 vectors plus random keys against a word-array expansion model.
module tb_aes_key_schedule;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_key_schedule_if if0();
  aes_key_schedule_if if1();

  aes_key_schedule #(.NUM_ROUNDS(10), .ERR_STICKY(1'b1)) dut0 (.clk(clk), .reset(reset), .ks(if0));
  aes_key_schedule #(.NUM_ROUNDS(10), .ERR_STICKY(1'b0)) dut1 (.clk(clk), .reset(reset), .ks(if1));

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_rk [11];
  logic [127:0] m_key;
  int           m_idx;
  int           m_st;     // 0 idle, 1 ready, 2 exhausted
  bit           m_valid, m_last, m_err0, m_err1;
  logic [7:0]   rcon_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Full 44-word schedule, then group four words per round key.
  task automatic expand_all(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive both buses, advance the model by the documented rules, settle past the edge.
  task automatic cycle(input bit rst, input bit ld, input logic [127:0] k, input bit rq);
    reset = rst;
    if0.load_key = ld; if0.cipher_key = k; if0.req_key = rq;
    if1.load_key = ld; if1.cipher_key = k; if1.req_key = rq;
    @(posedge clk);
    if (rst) begin
      m_key = '0; m_idx = 0; m_valid = 0; m_last = 0; m_err0 = 0; m_err1 = 0; m_st = 0;
    end else if (ld) begin
      expand_all(k);
      m_key = k; m_idx = 0; m_valid = 1; m_last = 0; m_err0 = 0; m_err1 = 0; m_st = 1;
    end else if (rq && m_st == 1) begin
      m_idx = m_idx + 1; m_key = m_rk[m_idx]; m_err1 = 0;
      if (m_idx == 10) begin m_st = 2; m_last = 1; end
    end else if (rq) begin
      m_err0 = 1; m_err1 = 1;
    end else begin
      m_err1 = 0;
    end
    #1;
    reset = 1'b0;
    if0.load_key = 1'b0; if0.req_key = 1'b0;
    if1.load_key = 1'b0; if1.req_key = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 0, '0, 0);
    cycle(1, 0, '0, 0);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_last, if0.key_err} !== {128'h0, 4'h0, 3'b000})
      $display("FAIL reset_state got %h/%0d/%b%b%b want all zero", if0.round_key, if0.round_idx, if0.key_valid, if0.key_last, if0.key_err);
    else n_pass++;
    cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_err} !== {m_key, 4'(m_idx), m_valid, m_err0})
      $display("FAIL idle_req got %h/%0d/v%b/e%b want %h/%0d/v%b/e%b", if0.round_key, if0.round_idx, if0.key_valid, if0.key_err, m_key, m_idx, m_valid, m_err0);
    else n_pass++;
    cycle(0, 0, '0, 0);
    n_total++;
    if (if0.key_err !== 1'b1) $display("FAIL idle_err_sticky got %b want 1", if0.key_err);
    else n_pass++;
    n_total++;
    if (if1.key_err !== 1'b0) $display("FAIL idle_err_pulse got %b want 0", if1.key_err);
    else n_pass++;
  endtask

  task automatic test_single_advance();
    cycle(0, 1, FIPS_KEY, 0);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_err} !== {FIPS_KEY, 4'd0, 1'b1, 1'b0})
      $display("FAIL load got %h/%0d/v%b/e%b want %h/0/v1/e0", if0.round_key, if0.round_idx, if0.key_valid, if0.key_err, FIPS_KEY);
    else n_pass++;
    cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_err} !== {FIPS_RK1, 4'd1, 1'b0})
      $display("FAIL fips_rk1 got %h/%0d/e%b want %h/1/e0", if0.round_key, if0.round_idx, if0.key_err, FIPS_RK1);
    else n_pass++;
    n_total++;
    if (if0.round_key !== m_key) $display("FAIL rk1_model got %h want %h", if0.round_key, m_key);
    else n_pass++;
  endtask

  task automatic test_full_sequence();
    cycle(0, 1, FIPS_KEY, 0);
    for (int r = 0; r < 10; r++) begin
      n_total++;
      if (dut0.r_rcon !== rcon_seq[r]) $display("FAIL rcon r%0d got %h want %h", r, dut0.r_rcon, rcon_seq[r]);
      else n_pass++;
      cycle(0, 0, '0, 1);
      n_total++;
      if ({if0.round_key, if0.round_idx, if0.key_last, if0.key_err} !== {m_key, 4'(m_idx), m_last, m_err0})
        $display("FAIL adv r%0d got %h/%0d/l%b/e%b want %h/%0d/l%b/e%b", r + 1, if0.round_key, if0.round_idx, if0.key_last, if0.key_err, m_key, m_idx, m_last, m_err0);
      else n_pass++;
      cycle(0, 0, '0, 0);
      cycle(0, 0, '0, 0);
      n_total++;
      if ({if0.round_key, if0.round_idx} !== {m_key, 4'(m_idx)})
        $display("FAIL hold r%0d got %h/%0d want %h/%0d", r + 1, if0.round_key, if0.round_idx, m_key, m_idx);
      else n_pass++;
    end
    n_total++;
    if ({if0.round_key, if0.key_last} !== {FIPS_RK10, 1'b1})
      $display("FAIL fips_rk10 got %h/l%b want %h/l1", if0.round_key, if0.key_last, FIPS_RK10);
    else n_pass++;
    n_total++;
    if (dut0.r_state !== EXHAUSTED) $display("FAIL exhausted_state got %0d want %0d", dut0.r_state, EXHAUSTED);
    else n_pass++;
  endtask

  task automatic test_exhausted_err();
    cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_err} !== {FIPS_RK10, 4'd10, 1'b1, 1'b1})
      $display("FAIL exh_req got %h/%0d/v%b/e%b want %h/10/v1/e1", if0.round_key, if0.round_idx, if0.key_valid, if0.key_err, FIPS_RK10);
    else n_pass++;
    n_total++;
    if (if1.key_err !== 1'b1) $display("FAIL exh_req_pulse got %b want 1", if1.key_err);
    else n_pass++;
    cycle(0, 0, '0, 0);
    n_total++;
    if ({if0.key_err, if1.key_err} !== {m_err0, m_err1})
      $display("FAIL exh_after got sticky=%b pulse=%b want %b %b", if0.key_err, if1.key_err, m_err0, m_err1);
    else n_pass++;
  endtask

  task automatic test_load_beats_req();
    logic [127:0] k1, k2;
    k1 = rand_key();
    k2 = rand_key();
    cycle(0, 1, k1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx} !== {m_key, 4'(m_idx)})
      $display("FAIL r5 got %h/%0d want %h/%0d", if0.round_key, if0.round_idx, m_key, m_idx);
    else n_pass++;
    cycle(0, 1, k2, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_err, if1.key_err} !== {k2, 4'd0, 1'b0, 1'b0})
      $display("FAIL load_beats_req got %h/%0d/e%b%b want %h/0/e00", if0.round_key, if0.round_idx, if0.key_err, if1.key_err, k2);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      cycle(0, 1, rand_key(), 0);
      for (int i = 0; i < n; i++) begin
        cycle(0, 0, '0, 1);
        n_total++;
        if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_last, if0.key_err, if1.key_err} !==
            {m_key, 4'(m_idx), m_valid, m_last, m_err0, m_err1})
          $display("FAIL b2b t%0d c%0d got %h/%0d/%b%b%b%b want %h/%0d/%b%b%b%b", t, i, if0.round_key, if0.round_idx,
                   if0.key_valid, if0.key_last, if0.key_err, if1.key_err, m_key, m_idx, m_valid, m_last, m_err0, m_err1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 1, rand_key(), 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1);
    n_total++;
    if (if0.round_idx !== 4'd4) $display("FAIL mid_idx got %0d want 4", if0.round_idx);
    else n_pass++;
    cycle(1, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_valid, if0.key_last, if0.key_err, if1.round_key} !== {128'h0, 4'h0, 3'b000, 128'h0})
      $display("FAIL mid_reset got %h/%0d/%b%b%b want all zero", if0.round_key, if0.round_idx, if0.key_valid, if0.key_last, if0.key_err);
    else n_pass++;
    cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.key_err, if0.key_valid} !== 2'b10) $display("FAIL post_reset_req got e%b v%b want e1 v0", if0.key_err, if0.key_valid);
    else n_pass++;
    cycle(0, 1, FIPS_KEY, 0);
    cycle(0, 0, '0, 1);
    n_total++;
    if ({if0.round_key, if0.round_idx, if0.key_err} !== {FIPS_RK1, 4'd1, 1'b0})
      $display("FAIL post_reset_rk1 got %h/%0d/e%b want %h/1/e0", if0.round_key, if0.round_idx, if0.key_err, FIPS_RK1);
    else n_pass++;
  endtask

  initial begin
    if0.load_key = 1'b0; if0.req_key = 1'b0; if0.cipher_key = '0;
    if1.load_key = 1'b0; if1.req_key = 1'b0; if1.cipher_key = '0;
    build_sbox();
    test_reset();
    test_single_advance();
    test_full_sequence();
    test_exhausted_err();
    test_load_beats_req();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
